// File: rtl/rx_quadro.sv
// Serial frame receiver: start, DATA_W data bits, INSTR_W instr bits (LSB first), stop; one bit per clk.
// Latency SYNC_STAGES+N+2 clk from start bit to valido/erro_quadro; no backpressure, line is consumed every cycle.
module rx_quadro #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 4,
  parameter int INSTR_W     = 4,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 info_entrada,
  output logic [DATA_W-1:0]    dado_rx,
  output logic [INSTR_W-1:0]   instrucao_rx,
  output logic                 valido,
  output logic                 erro_quadro,
  output logic                 ocupado,
  output logic [ERR_CNT_W-1:0] erros_total
);

  localparam int N     = DATA_W + INSTR_W;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(N - 1);

  localparam logic [1:0] OCIOSO        = 2'd0;
  localparam logic [1:0] RECEBE        = 2'd1;
  localparam logic [1:0] PARADA        = 2'd2;
  localparam logic [1:0] AGUARDA_LINHA = 2'd3;

  logic s;

  // Synchroniser resets to the idle-high level so reset never looks like a start bit.
  generate
    if (SYNC_STAGES > 0) begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sync_q <= '1;
        end else begin
          sync_q[0] <= info_entrada;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end
      assign s = sync_q[SYNC_STAGES-1];
    end else begin : g_direto
      assign s = info_entrada;
    end
  endgenerate

  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [N-1:0]         shift_q, shift_d;
  logic [DATA_W-1:0]    dado_q, dado_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic                 valido_q, valido_d;
  logic                 erro_q, erro_d;
  logic [ERR_CNT_W-1:0] errs_q, errs_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    dado_d   = dado_q;
    instr_d  = instr_q;
    valido_d = 1'b0;
    erro_d   = 1'b0;
    errs_d   = errs_q;
    case (state_q)
      OCIOSO: begin
        if (!s) begin
          state_d = RECEBE;
          cnt_d   = '0;
        end
      end
      RECEBE: begin
        // Shift in at the MSB so the first bit received ends up at bit 0.
        shift_d = {s, shift_q[N-1:1]};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == ULTIMO) begin
          state_d = PARADA;
        end
      end
      PARADA: begin
        if (s) begin
          dado_d   = shift_q[DATA_W-1:0];
          instr_d  = shift_q[N-1:DATA_W];
          valido_d = 1'b1;
          state_d  = OCIOSO;
        end else begin
          erro_d  = 1'b1;
          if (!(&errs_q)) begin
            errs_d = errs_q + 1'b1;
          end
          state_d = AGUARDA_LINHA;
        end
      end
      AGUARDA_LINHA: begin
        if (s) begin
          state_d = OCIOSO;
        end
      end
      default: state_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= OCIOSO;
      cnt_q    <= '0;
      shift_q  <= '0;
      dado_q   <= '0;
      instr_q  <= '0;
      valido_q <= 1'b0;
      erro_q   <= 1'b0;
      errs_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      dado_q   <= dado_d;
      instr_q  <= instr_d;
      valido_q <= valido_d;
      erro_q   <= erro_d;
      errs_q   <= errs_d;
    end
  end

  assign dado_rx      = dado_q;
  assign instrucao_rx = instr_q;
  assign valido       = valido_q;
  assign erro_quadro  = erro_q;
  assign erros_total  = errs_q;
  assign ocupado      = (state_q == RECEBE) || (state_q == PARADA);

endmodule

// File: tb/tb_rx_quadro.sv
// Bench for rx_quadro: three instances (default, 2-bit error counter, direct sampling)
// checked every cycle against a frame-level expectation queue.
module tb_rx_quadro;

  logic       clk = 1'b0;
  logic       rst;
  logic       ln     [3];
  logic [3:0] dado   [3];
  logic [3:0] instr  [3];
  logic       valido [3];
  logic       erro   [3];
  logic       ocup   [3];
  logic [7:0] errs0, errs2;
  logic [1:0] errs1;

  always #5 clk = ~clk;

  rx_quadro u_dut0 (
    .clk(clk), .rst(rst), .info_entrada(ln[0]), .dado_rx(dado[0]), .instrucao_rx(instr[0]),
    .valido(valido[0]), .erro_quadro(erro[0]), .ocupado(ocup[0]), .erros_total(errs0));
  rx_quadro #(.ERR_CNT_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .info_entrada(ln[1]), .dado_rx(dado[1]), .instrucao_rx(instr[1]),
    .valido(valido[1]), .erro_quadro(erro[1]), .ocupado(ocup[1]), .erros_total(errs1));
  rx_quadro #(.SYNC_STAGES(0)) u_dut2 (
    .clk(clk), .rst(rst), .info_entrada(ln[2]), .dado_rx(dado[2]), .instrucao_rx(instr[2]),
    .valido(valido[2]), .erro_quadro(erro[2]), .ocupado(ocup[2]), .erros_total(errs2));

  int syncs   [3] = '{2, 2, 0};
  int err_max [3] = '{255, 3, 255};

  typedef struct {
    int         d;
    int         cyc;
    logic       good;
    logic [3:0] dat;
    logic [3:0] ins;
  } ev_t;

  ev_t        evq[$];
  logic [3:0] m_dado [3];
  logic [3:0] m_ins  [3];
  int         m_err  [3];
  int         last_v [3];
  int         prev_v [3];
  int         cyc  = 0;
  int         nchk = 0;
  int         nerr = 0;

  function automatic int get_errs(input int d);
    case (d)
      0:       return int'(errs0);
      1:       return int'(errs1);
      default: return int'(errs2);
    endcase
  endfunction

  task automatic chk(input string nm, input int d, input longint act, input longint exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", nm, d, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    evq.delete();
    for (int d = 0; d < 3; d++) begin
      m_dado[d] = '0;
      m_ins[d]  = '0;
      m_err[d]  = 0;
    end
  endtask

  // Frame-level reference: each frame contributes one event at start+SYNC+N+2 and a busy window before it.
  logic m_hit, m_good, m_busy;
  int   m_idx;
  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int d = 0; d < 3; d++) begin
      m_hit = 1'b0; m_good = 1'b0; m_busy = 1'b0; m_idx = -1;
      for (int i = 0; i < evq.size(); i++) begin
        if (evq[i].d == d) begin
          if (evq[i].cyc == cyc) begin
            m_hit = 1'b1; m_good = evq[i].good; m_idx = i;
            if (evq[i].good) begin
              m_dado[d] = evq[i].dat;
              m_ins[d]  = evq[i].ins;
            end else if (m_err[d] < err_max[d]) begin
              m_err[d]++;
            end
          end
          if (cyc >= evq[i].cyc - 9 && cyc <= evq[i].cyc - 1) m_busy = 1'b1;
        end
      end
      if (m_idx >= 0) evq.delete(m_idx);
      chk("valido", d, valido[d], m_hit && m_good);
      chk("erro_quadro", d, erro[d], m_hit && !m_good);
      chk("ocupado", d, ocup[d], m_busy);
      chk("dado_rx", d, dado[d], m_dado[d]);
      chk("instrucao_rx", d, instr[d], m_ins[d]);
      chk("erros_total", d, get_errs(d), m_err[d]);
      if (valido[d]) begin
        prev_v[d] = last_v[d];
        last_v[d] = cyc;
      end
    end
  end

  task automatic idle(input int d, input int n);
    repeat (n) begin
      @(posedge clk); #1;
      ln[d] = 1'b1;
    end
  endtask

  task automatic hold_low(input int d, input int n);
    repeat (n) begin
      @(posedge clk); #1;
      ln[d] = 1'b0;
    end
  endtask

  task automatic send_frame(input int d, input logic [3:0] dat, input logic [3:0] ins,
                            input logic stop, output int start_p);
    logic [9:0] bits;
    ev_t        e;
    bits = {stop, ins, dat, 1'b0};
    start_p = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        start_p = cyc + 1;
        e.d = d; e.cyc = start_p + syncs[d] + 10; e.good = stop; e.dat = dat; e.ins = ins;
        evq.push_back(e);
      end
      ln[d] = bits[i];
    end
  endtask

  typedef struct {
    int         d;
    logic [3:0] dat;
    logic [3:0] ins;
    logic       stop;
    logic [3:0] e_dat;
    logic [3:0] e_ins;
    int         e_err;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int st, st2, d, gap;
    logic stop;

    tbl[0] = '{0, 4'hA, 4'h5, 1'b1, 4'hA, 4'h5, 0};
    tbl[1] = '{2, 4'h6, 4'h9, 1'b1, 4'h6, 4'h9, 0};
    tbl[2] = '{1, 4'h3, 4'hC, 1'b0, 4'h0, 4'h0, 1};
    tbl[3] = '{1, 4'h7, 4'h1, 1'b0, 4'h0, 4'h0, 2};
    tbl[4] = '{1, 4'hE, 4'h2, 1'b0, 4'h0, 4'h0, 3};
    tbl[5] = '{1, 4'h0, 4'hF, 1'b0, 4'h0, 4'h0, 3};
    tbl[6] = '{1, 4'h9, 4'h9, 1'b0, 4'h0, 4'h0, 3};
    tbl[7] = '{1, 4'h2, 4'hB, 1'b1, 4'h2, 4'hB, 3};

    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ln[i] = 1'b1; last_v[i] = 0; prev_v[i] = 0;
    end
    model_clear();
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;

    @(negedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset valido", i, valido[i], 0);
      chk("reset erro", i, erro[i], 0);
      chk("reset ocupado", i, ocup[i], 0);
      chk("reset dado", i, dado[i], 0);
      chk("reset instr", i, instr[i], 0);
      chk("reset erros", i, get_errs(i), 0);
    end

    foreach (tbl[k]) begin
      idle(tbl[k].d, 2);
      send_frame(tbl[k].d, tbl[k].dat, tbl[k].ins, tbl[k].stop, st);
      idle(tbl[k].d, 4);
      chk("tbl dado", tbl[k].d, dado[tbl[k].d], tbl[k].e_dat);
      chk("tbl instr", tbl[k].d, instr[tbl[k].d], tbl[k].e_ins);
      chk("tbl erros", tbl[k].d, get_errs(tbl[k].d), tbl[k].e_err);
      if (tbl[k].stop) chk("tbl latency", tbl[k].d, last_v[tbl[k].d] - st, syncs[tbl[k].d] + 10);
    end

    // Bad stop bit followed by a low line must not be mistaken for a new frame.
    send_frame(0, 4'h3, 4'hC, 1'b0, st);
    hold_low(0, 3);
    idle(0, 4);
    chk("ferr erros", 0, errs0, 1);
    chk("ferr dado", 0, dado[0], 4'hA);
    chk("ferr instr", 0, instr[0], 4'h5);

    send_frame(0, 4'h1, 4'h8, 1'b1, st);
    idle(0, 1);
    send_frame(0, 4'hF, 4'h0, 1'b1, st2);
    idle(0, 5);
    chk("b2b spacing", 0, last_v[0] - prev_v[0], 11);
    chk("b2b dado", 0, dado[0], 4'hF);
    chk("b2b instr", 0, instr[0], 4'h0);

    // Reset asserted while data bit 2 is on the line.
    @(posedge clk); #1 ln[0] = 1'b0;
    @(posedge clk); #1 ln[0] = 1'b1;
    @(posedge clk); #1 ln[0] = 1'b1;
    @(posedge clk); #1 ln[0] = 1'b1;
    #1 rst = 1'b0;
    model_clear();
    #1;
    chk("rst dado", 0, dado[0], 0);
    chk("rst instr", 0, instr[0], 0);
    chk("rst erros", 0, errs0, 0);
    chk("rst ocupado", 0, ocup[0], 0);
    ln[0] = 1'b1;
    @(posedge clk);
    @(negedge clk); #2 rst = 1'b1;
    idle(0, 3);
    send_frame(0, 4'hC, 4'h3, 1'b1, st);
    idle(0, 5);
    chk("post-rst dado", 0, dado[0], 4'hC);
    chk("post-rst instr", 0, instr[0], 4'h3);

    for (int n = 0; n < 60; n++) begin
      d    = $urandom_range(0, 2);
      stop = ($urandom_range(0, 3) != 0);
      gap  = $urandom_range(0, 2);
      if (!stop && gap == 0) gap = 1;
      send_frame(d, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), stop, st);
      idle(d, gap);
    end
    for (int i = 0; i < 3; i++) idle(i, 2);
    idle(0, 6);
    chk("pending events", 0, evq.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
